evo_i2c_target: RTL and testbench
=================================

Name: evo_i2c_target

Overview:
- I2C target (responder) for the EVO I2C_Reg interface. It answers a host controller on the external SCL/SDA pins at a 7-bit address.
- It maps a register pointer plus data bytes onto a simple local register bus. The fabric-side register file (INFO, REG0E, REG0F, ...) sits behind that bus.
- It is the responder counterpart to the on-chip TWI controller, and runs in the fabric clock domain with oversampled pins.

Parameters:
- I2C_ADDR, 7'h10, 7-bit target address (matches the default I2C ID 0x10).
- REG_AWIDTH, 4, register pointer width; the pointer wraps at 2**REG_AWIDTH.
- FILT_LEN, 3, number of consecutive equal synchronized samples required to accept an SCL/SDA level change.

Ports:
- clk  in  1  fabric clock.
- rstn  in  1  asynchronous, active-low reset.
- scl_in  in  1  raw SCL pin level.
- sda_in  in  1  raw SDA pin level.
- sda_oe  out  1  1 = drive SDA low (open drain). This block never drives high.
- wr_en  out  1  one-cycle write strobe to the register bus.
- wr_addr  out  REG_AWIDTH  write register index.
- wr_data  out  8  write byte.
- rd_en  out  1  one-cycle read request.
- rd_addr  out  REG_AWIDTH  read register index.
- rd_data  in  8  read byte; valid exactly one clk after rd_en.
- busy  out  1  high from an address-matched START until STOP or NACK/mismatch return to idle.

Behaviour:
- Reset: sda_oe=0, wr_en=0, rd_en=0, busy=0, wr_addr=0, rd_addr=0, wr_data=0. Pointer=0, state=IDLE, filtered SCL/SDA=1.
- Input conditioning: 2-flop synchronizer, then a FILT_LEN glitch filter per line. Edge detect operates on the filtered levels only.
- START / repeated START: filtered SDA falls while SCL is high. It is accepted in any state: go to ADDR, clear the bit counter, release sda_oe.
- STOP: filtered SDA rises while SCL is high. Go to IDLE, release sda_oe, busy=0.
- Bit timing: sample SDA on SCL rising. Update sda_oe one clk after SCL falling. Bytes are MSB first.
- ADDR: shift 8 bits.
  - Bits [7:1]==I2C_ADDR: ADDR_ACK (drive 0 for the ACK bit), busy=1. Then R/W=0 -> PTR, R/W=1 -> RD_LOAD.
  - Mismatch: IGNORE (sda_oe=0 until the next START/STOP).
- PTR: shift 8 bits; pointer = byte[REG_AWIDTH-1:0]. ACK, then WDATA.
- WDATA: shift 8 bits. On the 8th SCL rising edge pulse wr_en with wr_addr=pointer and wr_data=byte, then pointer += 1 (wraps). ACK, then WDATA. Every byte is ACKed.
- RD_LOAD: pulse rd_en with rd_addr=pointer on the SCL falling edge that ends the ACK bit. Capture rd_data one clk later into the shift register, then pointer += 1. Then RDATA.
- RDATA: after each SCL falling, sda_oe = ~shift[MSB]. After 8 bits, release SDA and sample the host ACK on SCL rising.
  - ACK (0): RD_LOAD for the next byte.
  - NACK (1): IGNORE.
- The pointer persists across transactions (write pointer, repeated START, then read works). The pointer resets only on rstn.
- SCL stretching: none. The fabric read latency is 1 clk, well inside the SCL low time.
- STOP or START mid-byte: abort the byte, emit no wr_en, and drop any partially shifted data.
- rstn asserted mid-transfer: immediate release of SDA and all outputs to reset values.
- A general call (address 0x00) is not supported and is treated as a mismatch.

Test Plan:
- Reset: rstn low with SCL/SDA toggling -> sda_oe=0, wr_en=0, rd_en=0, busy=0 throughout.
- Write: START, 0x20 (addr 0x10, W), 0x0E, 0xA5, 0x5A, STOP -> ACK on all 4 bytes. wr_en pulses (0xE, 0xA5) then (0xF, 0x5A). busy falls at STOP.
- Read with wrap: write pointer 0x0F, repeated START, 0x21, host ACKs byte 1 and NACKs byte 2. Bench returns rd_data=0x3C for addr 0xF and 0x77 for addr 0x0 -> SDA carries 0x3C then 0x77, rd_addr sequence 0xF, 0x0, then idle.
- Address mismatch: START, 0x22 (addr 0x11), 0x0E, STOP -> sda_oe never asserted, no wr_en/rd_en, busy=0.
- Glitch/abort: 1-clk SDA pulse while SCL high -> no START/STOP detected. STOP after 4 bits of a WDATA byte -> no wr_en, state IDLE.
- Async reset mid-read while sda_oe=1 -> sda_oe=0 within the same clk. The next transaction behaves as from reset with pointer=0.

Source files
------------

// File: rtl/evo_i2c_target.sv
`default_nettype none
// ============================================================================
// Module   : evo_i2c_target
// Purpose  : I2C target (responder) for the EVO I2C_Reg interface. Listens
//            on oversampled SCL/SDA at a 7-bit address and maps a register
//            pointer plus data bytes onto a one-cycle local register bus.
// Revision : 1.0 - initial release
// ============================================================================
module evo_i2c_target #(
  parameter logic [6:0] I2C_ADDR   = 7'h10,
  parameter int         REG_AWIDTH = 4,
  parameter int         FILT_LEN   = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  wr_en,
  output logic [REG_AWIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  rd_en,
  output logic [REG_AWIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  busy
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RD_LOAD   = 4'd7,
    S_RDATA     = 4'd8,
    S_RD_ACK    = 4'd9,
    S_IGNORE    = 4'd10
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic [1:0]          scl_sync, sda_sync;
  logic [FILT_LEN-1:0] scl_hist, sda_hist;
  logic                scl_f, sda_f, scl_prev, sda_prev;

  // Two-flop synchronizers feeding a sample history per line
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= '1;
      sda_hist <= '1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[1]};
    end
  end

  // Glitch filter: a level is accepted only after FILT_LEN equal samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      if (scl_hist == {FILT_LEN{1'b1}})      scl_f <= 1'b1;
      else if (scl_hist == {FILT_LEN{1'b0}}) scl_f <= 1'b0;
      if (sda_hist == {FILT_LEN{1'b1}})      sda_f <= 1'b1;
      else if (sda_hist == {FILT_LEN{1'b0}}) sda_f <= 1'b0;
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f & scl_prev;
  // SCL must be high on both samples so an SCL edge never masquerades as
  // a bus condition
  assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

  // --------------------------------------------------------------------------
  // Protocol engine
  // --------------------------------------------------------------------------
  state_t                state, state_nxt;
  logic [7:0]            shift, shift_nxt;
  logic [3:0]            bit_cnt, bit_cnt_nxt;
  logic [REG_AWIDTH-1:0] ptr, ptr_nxt;
  logic                  rw, rw_nxt;
  logic                  sda_oe_nxt, wr_en_nxt, rd_en_nxt, busy_nxt;
  logic [REG_AWIDTH-1:0] wr_addr_nxt, rd_addr_nxt;
  logic [7:0]            wr_data_nxt;

  logic [7:0] byte_in;
  logic       last_bit;
  logic       addr_match;
  assign byte_in    = {shift[6:0], sda_f};
  assign last_bit   = (bit_cnt == 4'd7);
  // General call (0x00) is never answered
  assign addr_match = (byte_in[7:1] == I2C_ADDR) && (byte_in[7:1] != 7'd0);

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      shift   <= 8'd0;
      bit_cnt <= 4'd0;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      ptr     <= ptr_nxt;
      rw      <= rw_nxt;
      sda_oe  <= sda_oe_nxt;
      wr_en   <= wr_en_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
      rd_en   <= rd_en_nxt;
      rd_addr <= rd_addr_nxt;
      busy    <= busy_nxt;
    end
  end

  // Next-state and output decode; bus conditions override every state
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    ptr_nxt     = ptr;
    rw_nxt      = rw;
    sda_oe_nxt  = sda_oe;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = rd_addr;
    busy_nxt    = busy;

    if (stop_det) begin
      state_nxt   = S_IDLE;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = 4'd0;
      shift_nxt   = 8'd0;
    end else if (start_det) begin
      state_nxt   = S_ADDR;
      sda_oe_nxt  = 1'b0;
      bit_cnt_nxt = 4'd0;
      shift_nxt   = 8'd0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise) begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (last_bit) begin
              if (addr_match) begin
                rw_nxt    = byte_in[0];
                busy_nxt  = 1'b1;
                state_nxt = S_ADDR_ACK;
              end else begin
                busy_nxt  = 1'b0;
                state_nxt = S_IGNORE;
              end
            end
          end
        end

        // ACK states: the first SCL fall starts driving the ACK, the
        // second one (sda_oe already set) ends the ACK bit
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 4'd0;
              shift_nxt   = 8'd0;
              if (rw) begin
                rd_en_nxt   = 1'b1;
                rd_addr_nxt = ptr;
                state_nxt   = S_RD_LOAD;
              end else begin
                state_nxt   = S_PTR;
              end
            end
          end
        end

        S_PTR: begin
          if (scl_rise) begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (last_bit) begin
              ptr_nxt   = byte_in[REG_AWIDTH-1:0];
              state_nxt = S_PTR_ACK;
            end
          end
        end

        S_WDATA: begin
          if (scl_rise) begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (last_bit) begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = ptr;
              wr_data_nxt = byte_in;
              ptr_nxt     = ptr + 1'b1;
              state_nxt   = S_WDATA_ACK;
            end
          end
        end

        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt  = 1'b0;
              bit_cnt_nxt = 4'd0;
              shift_nxt   = 8'd0;
              state_nxt   = S_WDATA;
            end
          end
        end

        // rd_data is valid the cycle after rd_en, so wait while rd_en is high
        S_RD_LOAD: begin
          if (!rd_en) begin
            shift_nxt   = rd_data;
            ptr_nxt     = ptr + 1'b1;
            sda_oe_nxt  = ~rd_data[7];
            bit_cnt_nxt = 4'd0;
            state_nxt   = S_RDATA;
          end
        end

        S_RDATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = S_RD_ACK;
            end else begin
              shift_nxt  = {shift[6:0], 1'b0};
              sda_oe_nxt = ~shift[6];
            end
          end
        end

        // bit_cnt==9 marks a host ACK seen on this bit
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_f) begin
              busy_nxt  = 1'b0;
              state_nxt = S_IGNORE;
            end else begin
              bit_cnt_nxt = 4'd9;
            end
          end else if (scl_fall && (bit_cnt == 4'd9)) begin
            bit_cnt_nxt = 4'd0;
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = ptr;
            state_nxt   = S_RD_LOAD;
          end
        end

        default: begin
          // S_IDLE and S_IGNORE wait for the next START/STOP
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_evo_i2c_target.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_evo_i2c_target
// Purpose  : Bus-level bench for evo_i2c_target: host I2C driver, register
//            bus model and scoreboards for writes, read addresses and bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_evo_i2c_target;

  localparam int Q = 12;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl_host = 1'b1;
  logic       sda_host = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_en, rd_en, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] mem [16];

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] wr_q  [$];
  logic [3:0]  rda_q [$];
  logic [7:0]  rdb_q [$];

  logic rst_watch = 1'b0;
  logic rst_bad   = 1'b0;
  logic oe_seen   = 1'b0;
  logic busy_seen = 1'b0;

  assign sda_line = sda_host & ~sda_oe;

  evo_i2c_target #(.I2C_ADDR(7'h10), .REG_AWIDTH(4), .FILT_LEN(3)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .scl_in  (scl_host),
    .sda_in  (sda_line),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h80 + i);
    mem[0]  = 8'h77;
    mem[4]  = 8'h12;
    mem[15] = 8'h3C;
  end

  // Register bus model: data valid for exactly one cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    else       rd_data <= 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor and scoreboard pops
  always @(negedge clk) begin
    if (rst_watch && (sda_oe || wr_en || rd_en || busy)) rst_bad = 1'b1;
    if (sda_oe) oe_seen = 1'b1;
    if (busy)   busy_seen = 1'b1;
    if (rstn && wr_en) begin
      if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        logic [11:0] e;
        e = wr_q.pop_front();
        check("wr_addr", wr_addr, e[11:8]);
        check("wr_data", wr_data, e[7:0]);
      end
    end
    if (rstn && rd_en) begin
      if (rda_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_addr", rd_addr, rda_q.pop_front());
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_host = 1'b1; wait_clk(Q);
    scl_host = 1'b1; wait_clk(Q);
    sda_host = 1'b0; wait_clk(Q);
    scl_host = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_host = 1'b0; wait_clk(Q);
    scl_host = 1'b1; wait_clk(Q);
    sda_host = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_host = b; wait_clk(Q);
    scl_host = 1'b1; wait_clk(Q);
    if (glitch) begin
      sda_host = ~b; wait_clk(1);
      sda_host = b;  wait_clk(Q - 1);
    end else begin
      wait_clk(Q);
    end
    scl_host = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_host = 1'b1; wait_clk(Q);
    scl_host = 1'b1; wait_clk(Q);
    b = sda_line;    wait_clk(Q);
    scl_host = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic host_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(host_ack, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] b;
    int         k;

    // Reset held while the pins toggle
    rst_watch = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      scl_host = i[0];
      sda_host = i[1];
    end
    rst_watch = 1'b0;
    check("rst_quiet", rst_bad, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_data", wr_data, 0);
    scl_host = 1'b1; sda_host = 1'b1;
    wait_clk(8);
    rstn = 1'b1;
    wait_clk(8);

    // Write 0xA5 to 0xE and 0x5A to 0xF
    i2c_start();
    send_byte(8'h20, -1, ack); check("w_ack_addr", ack, 0);
    send_byte(8'h0E, -1, ack); check("w_ack_ptr", ack, 0);
    wr_q.push_back({4'hE, 8'hA5});
    send_byte(8'hA5, -1, ack); check("w_ack_d0", ack, 0);
    wr_q.push_back({4'hF, 8'h5A});
    send_byte(8'h5A, -1, ack); check("w_ack_d1", ack, 0);
    check("w_busy_high", busy, 1);
    i2c_stop();
    wait_clk(10);
    check("w_busy_low", busy, 0);
    check("w_wr_q_empty", wr_q.size(), 0);

    // Pointer 0x0F, repeated START, read two bytes across the wrap
    i2c_start();
    send_byte(8'h20, -1, ack); check("r_ack_addr_w", ack, 0);
    send_byte(8'h0F, -1, ack); check("r_ack_ptr", ack, 0);
    i2c_start();
    rda_q.push_back(4'hF); rda_q.push_back(4'h0);
    rdb_q.push_back(8'h3C); rdb_q.push_back(8'h77);
    send_byte(8'h21, -1, ack); check("r_ack_addr_r", ack, 0);
    recv_byte(b, 1'b0); check("r_byte0", b, rdb_q.pop_front());
    recv_byte(b, 1'b1); check("r_byte1", b, rdb_q.pop_front());
    wait_clk(4);
    check("r_busy_nack", busy, 0);
    i2c_stop();
    wait_clk(10);
    check("r_rda_q_empty", rda_q.size(), 0);

    // Address mismatch
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    send_byte(8'h22, -1, ack); check("mm_nack_addr", ack, 1);
    send_byte(8'h0E, -1, ack); check("mm_nack_data", ack, 1);
    i2c_stop();
    wait_clk(10);
    check("mm_oe_never", oe_seen, 0);
    check("mm_busy_never", busy_seen, 0);

    // One-clk SDA low pulse with SCL high must not be a START
    busy_seen = 1'b0;
    sda_host = 1'b0; wait_clk(1);
    sda_host = 1'b1; wait_clk(Q);
    scl_host = 1'b0; wait_clk(Q);
    send_byte(8'h20, -1, ack); check("gl_start_nack", ack, 1);
    i2c_stop();
    wait_clk(10);
    check("gl_start_busy", busy_seen, 0);

    // One-clk SDA high pulse inside a data bit must not be a STOP
    i2c_start();
    send_byte(8'h20, -1, ack); check("gl_ack_addr", ack, 0);
    send_byte(8'h03, -1, ack); check("gl_ack_ptr", ack, 0);
    wr_q.push_back({4'h3, 8'h11});
    send_byte(8'h11, 7, ack); check("gl_stop_ack", ack, 0);
    // Abort a data byte after 4 bits
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    i2c_stop();
    wait_clk(10);
    check("ab_busy", busy, 0);
    // Back in IDLE: a byte without START is ignored
    scl_host = 1'b0; wait_clk(Q);
    send_byte(8'h20, -1, ack); check("ab_idle_nack", ack, 1);
    i2c_stop();
    wait_clk(10);
    check("ab_wr_q_empty", wr_q.size(), 0);

    // Async reset while the target is driving SDA low
    rda_q.push_back(4'h4);
    i2c_start();
    send_byte(8'h21, -1, ack); check("ar_ack_addr", ack, 0);
    k = 0;
    while (!sda_oe && k < 60) begin
      wait_clk(1);
      k++;
    end
    check("ar_oe_driven", sda_oe, 1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("ar_oe_release", sda_oe, 0);
    check("ar_busy", busy, 0);
    check("ar_rd_addr", rd_addr, 0);
    scl_host = 1'b1; sda_host = 1'b1;
    wait_clk(10);
    rstn = 1'b1;
    wait_clk(10);
    check("ar_rda_q_empty", rda_q.size(), 0);

    // Next read starts from pointer 0
    rda_q.push_back(4'h0);
    rdb_q.push_back(8'h77);
    i2c_start();
    send_byte(8'h21, -1, ack); check("pr_ack_addr", ack, 0);
    recv_byte(b, 1'b1); check("pr_byte0", b, rdb_q.pop_front());
    i2c_stop();
    wait_clk(10);
    check("pr_rda_q_empty", rda_q.size(), 0);
    check("pr_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
